// File: rtl/sseg_pkg.sv
// Shared types, active-low segment patterns ({dp,g,f,e,d,c,b,a}) and the BCD
// digit decode function used by the seven-segment scan driver.
package sseg_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Non-decimal codes render as a dash so corrupt digits are visible.
  function automatic logic [7:0] bcd2seg(input bcd_digit_t v);
    case (v)
      4'd0:    bcd2seg = SEG_0;
      4'd1:    bcd2seg = SEG_1;
      4'd2:    bcd2seg = SEG_2;
      4'd3:    bcd2seg = SEG_3;
      4'd4:    bcd2seg = SEG_4;
      4'd5:    bcd2seg = SEG_5;
      4'd6:    bcd2seg = SEG_6;
      4'd7:    bcd2seg = SEG_7;
      4'd8:    bcd2seg = SEG_8;
      4'd9:    bcd2seg = SEG_9;
      default: bcd2seg = SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/sseg_digit_dec.sv
// Combinational decoder from one BCD digit to its active-low segment pattern.
module sseg_digit_dec
  import sseg_pkg::*;
(
  input  bcd_digit_t  digit,
  output logic [7:0]  seg
);

  assign seg = bcd2seg(digit);

endmodule

// File: rtl/bcd_sseg_scan.sv
// Four-digit multiplexed seven-segment driver with frame-synchronous updates,
// overflow blinking and optional leading-zero blanking (macro LZ_BLANK_EN).
module bcd_sseg_scan
  import sseg_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] bcd_in,
  input  logic        ovf_in,
  output logic [7:0]  sseg,
  output logic [7:0]  an,
  output logic        frame
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(REFRESH_DIV - 1);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FCNT_MAX = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] pcnt;
  logic [1:0]    dig;
  logic          pwrap;
  logic          fb;

  logic [15:0]   pend_bcd;
  logic          pend_ovf;
  logic          pend_v;
  logic [15:0]   shad_bcd;
  logic          shad_ovf;

  logic [FW-1:0] fcnt;
  logic          blink_ph;

  bcd_digit_t    sel_digit;
  logic [7:0]    dec_seg;
  logic          lz_blank;

  assign pwrap = (pcnt == PCNT_MAX);
  assign fb    = pwrap && (dig == 2'd3);

  // Slot timing: prescaler and digit index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt <= '0;
      dig  <= 2'd0;
    end else if (pwrap) begin
      pcnt <= '0;
      dig  <= dig + 2'd1;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Pending data needs no reset: pend_v alone decides whether it is used.
  always_ff @(posedge clk) begin
    if (load) begin
      pend_bcd <= bcd_in;
      pend_ovf <= ovf_in;
    end
  end

  // Shadow only changes on the frame boundary, so a frame never mixes values
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_v   <= 1'b0;
      shad_bcd <= '0;
      shad_ovf <= 1'b0;
    end else if (fb) begin
      pend_v <= 1'b0;
      if (load) begin
        shad_bcd <= bcd_in;
        shad_ovf <= ovf_in;
      end else if (pend_v) begin
        shad_bcd <= pend_bcd;
        shad_ovf <= pend_ovf;
      end
    end else if (load) begin
      pend_v <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fcnt     <= '0;
      blink_ph <= 1'b0;
    end else if (fb) begin
      if (fcnt == FCNT_MAX) begin
        fcnt     <= '0;
        blink_ph <= ~blink_ph;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // Digit select and decode on the current slot
  always_comb begin
    sel_digit = shad_bcd[3:0];
    case (dig)
      2'd1:    sel_digit = shad_bcd[7:4];
      2'd2:    sel_digit = shad_bcd[11:8];
      2'd3:    sel_digit = shad_bcd[15:12];
      default: sel_digit = shad_bcd[3:0];
    endcase
  end

  sseg_digit_dec u_dec (
    .digit (sel_digit),
    .seg   (dec_seg)
  );

`ifdef LZ_BLANK_EN
  logic [1:0] msd;

  // Any nonzero code, including invalid ones, counts as significant.
  always_comb begin
    msd = 2'd0;
    if (shad_bcd[15:12] != 4'd0)     msd = 2'd3;
    else if (shad_bcd[11:8] != 4'd0) msd = 2'd2;
    else if (shad_bcd[7:4] != 4'd0)  msd = 2'd1;
  end

  assign lz_blank = (dig > msd);
`else
  assign lz_blank = 1'b0;
`endif

  // Output register: drives the board pins one cycle after the slot state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sseg  <= SEG_BLANK;
      an    <= 8'hFF;
      frame <= 1'b0;
    end else begin
      sseg  <= lz_blank ? SEG_BLANK : dec_seg;
      an    <= (shad_ovf && blink_ph) ? 8'hFF : ~(8'h01 << dig);
      frame <= fb;
    end
  end

endmodule
